// File: rtl/ahb_slave_port_if.sv
// +----------------------------------------------------------------------------+
// | ahb_slave_port_if                                                          |
// | Per-master request/return buses and one slave's AHB bus, one port's view.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ahb_slave_port_if #(
  parameter int MASTERS = 8
);
  logic [MASTERS-1:0]    m_addr_req;
  logic [MASTERS-1:0]    m_hsel;
  logic [MASTERS-1:0]    m_hwrite;
  logic [MASTERS-1:0]    m_hmastlock;
  logic [2*MASTERS-1:0]  m_htrans;
  logic [3*MASTERS-1:0]  m_hsize;
  logic [3*MASTERS-1:0]  m_hburst;
  logic [4*MASTERS-1:0]  m_hprot;
  logic [32*MASTERS-1:0] m_haddr;
  logic [32*MASTERS-1:0] m_hwdata;
  logic [MASTERS-1:0]    m_addr_ack;
  logic [MASTERS-1:0]    m_data_ack;
  logic [32*MASTERS-1:0] m_hrdata;
  logic [MASTERS-1:0]    m_hresp;

  logic        S_HSEL;
  logic        S_HWRITE;
  logic        S_HMASTLOCK;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE;
  logic [2:0]  S_HBURST;
  logic [3:0]  S_HPROT;
  logic [31:0] S_HADDR;
  logic [31:0] S_HWDATA;
  logic        S_HREADY;
  logic        S_HREADYOUT;
  logic [31:0] S_HRDATA;
  logic        S_HRESP;

  modport slave (
    input  m_addr_req, m_hsel, m_hwrite, m_hmastlock, m_htrans, m_hsize,
           m_hburst, m_hprot, m_haddr, m_hwdata,
           S_HREADYOUT, S_HRDATA, S_HRESP,
    output m_addr_ack, m_data_ack, m_hrdata, m_hresp,
           S_HSEL, S_HWRITE, S_HMASTLOCK, S_HTRANS, S_HSIZE, S_HBURST,
           S_HPROT, S_HADDR, S_HWDATA, S_HREADY
  );

  modport master (
    output m_addr_req, m_hsel, m_hwrite, m_hmastlock, m_htrans, m_hsize,
           m_hburst, m_hprot, m_haddr, m_hwdata,
           S_HREADYOUT, S_HRDATA, S_HRESP,
    input  m_addr_ack, m_data_ack, m_hrdata, m_hresp,
           S_HSEL, S_HWRITE, S_HMASTLOCK, S_HTRANS, S_HSIZE, S_HBURST,
           S_HPROT, S_HADDR, S_HWDATA, S_HREADY
  );
endinterface

`default_nettype wire

// File: rtl/ahb_slave_port.sv
// +----------------------------------------------------------------------------+
// | ahb_slave_port                                                             |
// | Arbitrates master requests onto one AHB slave and routes its data phase.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ahb_slave_port #(
  parameter int          MASTERS    = 8,
  parameter logic [31:0] SLAVE_BASE = 32'h0000_0000,
  parameter logic [31:0] SLAVE_MASK = 32'hF000_0000
) (
  input  wire logic       HCLK,
  input  wire logic       HRESETn,
  ahb_slave_port_if.slave bus
);

  localparam int                   c_PTR_W    = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [c_PTR_W-1:0]   c_RR_RESET = c_PTR_W'(MASTERS - 1);
  localparam logic [c_PTR_W:0]     c_MASTERS  = (c_PTR_W + 1)'(MASTERS);

  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [c_PTR_W-1:0] r_d_owner;
  logic               r_d_valid;
  logic [c_PTR_W-1:0] r_lock_owner;
  logic               r_lock_valid;

  logic [MASTERS-1:0] w_q;
  logic               w_gnt_valid;
  logic [c_PTR_W-1:0] w_gnt;
  logic [c_PTR_W:0]   w_sum;
  logic               w_addr_ack;

  generate
    for (genvar i = 0; i < MASTERS; i++) begin : g_req
      assign w_q[i] = bus.m_addr_req[i] & bus.m_hsel[i] &
                      ((bus.m_haddr[32*i +: 32] & SLAVE_MASK) == SLAVE_BASE);
    end
  endgenerate

  // Round-robin search from r_rr_ptr+1; descending k so the nearest requester wins.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    w_sum       = '0;
    if (HRESETn) begin
      if (r_lock_valid) begin
        w_gnt_valid = w_q[r_lock_owner];
        w_gnt       = r_lock_owner;
      end else begin
        for (int k = MASTERS; k >= 1; k--) begin
          w_sum = {1'b0, r_rr_ptr} + (c_PTR_W + 1)'(k);
          if (w_sum >= c_MASTERS) begin
            w_sum = w_sum - c_MASTERS;
          end
          if (w_q[w_sum[c_PTR_W-1:0]]) begin
            w_gnt_valid = 1'b1;
            w_gnt       = w_sum[c_PTR_W-1:0];
          end
        end
      end
    end
  end

  assign w_addr_ack = w_gnt_valid & bus.S_HREADYOUT;

  always_comb begin
    bus.S_HSEL      = 1'b0;
    bus.S_HWRITE    = 1'b0;
    bus.S_HMASTLOCK = 1'b0;
    bus.S_HTRANS    = 2'b00;
    bus.S_HSIZE     = 3'b000;
    bus.S_HBURST    = 3'b000;
    bus.S_HPROT     = 4'b0000;
    bus.S_HADDR     = 32'h0;
    if (w_gnt_valid) begin
      bus.S_HSEL      = 1'b1;
      bus.S_HWRITE    = bus.m_hwrite[w_gnt];
      bus.S_HMASTLOCK = bus.m_hmastlock[w_gnt];
      bus.S_HTRANS    = bus.m_htrans[2*int'(w_gnt) +: 2];
      bus.S_HSIZE     = bus.m_hsize[3*int'(w_gnt) +: 3];
      bus.S_HBURST    = bus.m_hburst[3*int'(w_gnt) +: 3];
      bus.S_HPROT     = bus.m_hprot[4*int'(w_gnt) +: 4];
      bus.S_HADDR     = bus.m_haddr[32*int'(w_gnt) +: 32];
    end
  end

  assign bus.S_HWDATA = r_d_valid ? bus.m_hwdata[32*int'(r_d_owner) +: 32] : 32'h0;
  assign bus.S_HREADY = bus.S_HREADYOUT;

  generate
    for (genvar i = 0; i < MASTERS; i++) begin : g_ret
      logic w_own;
      assign w_own                  = r_d_valid & (r_d_owner == c_PTR_W'(i));
      assign bus.m_addr_ack[i]      = w_addr_ack & (w_gnt == c_PTR_W'(i));
      assign bus.m_data_ack[i]      = w_own & bus.S_HREADYOUT;
      assign bus.m_hrdata[32*i +: 32] = w_own ? bus.S_HRDATA : 32'h0;
      assign bus.m_hresp[i]         = w_own & bus.S_HRESP;
    end
  endgenerate

  // An accepted address phase takes priority over the idle-owner lock release.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rr_ptr     <= c_RR_RESET;
      r_d_valid    <= 1'b0;
      r_d_owner    <= '0;
      r_lock_valid <= 1'b0;
      r_lock_owner <= '0;
    end else if (w_addr_ack) begin
      r_rr_ptr  <= w_gnt;
      r_d_owner <= w_gnt;
      r_d_valid <= 1'b1;
      if (bus.m_hmastlock[w_gnt]) begin
        r_lock_valid <= 1'b1;
        r_lock_owner <= w_gnt;
      end else if (r_lock_valid && (w_gnt == r_lock_owner)) begin
        r_lock_valid <= 1'b0;
      end
    end else begin
      if (bus.S_HREADYOUT) begin
        r_d_valid <= 1'b0;
      end
      if (!r_d_valid && !w_q[r_lock_owner]) begin
        r_lock_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_port.sv
// +----------------------------------------------------------------------------+
// | tb_ahb_slave_port                                                          |
// | Directed and random stimulus against a transaction-level arbiter model.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ahb_slave_port;

  localparam int          M    = 5;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] MASK = 32'hF000_0000;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_slave_port_if #(.MASTERS(M)) bus ();

  ahb_slave_port #(.MASTERS(M), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  bit          t_req[M], t_sel[M], t_wr[M], t_lock[M];
  logic [1:0]  t_trans[M];
  logic [2:0]  t_size[M], t_burst[M];
  logic [3:0]  t_prot[M];
  logic [31:0] t_addr[M], t_wdata[M];
  bit          t_rdy, t_resp;
  logic [31:0] t_rdata;

  // Reference state: who last won, who owns the data phase, who holds the lock.
  int mr_rr, mr_down, mr_lo;
  bit mr_dv, mr_lv;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit qual(int i);
    return t_req[i] && t_sel[i] && ((t_addr[i] & MASK) == BASE);
  endfunction

  function automatic int pick();
    if (HRESETn !== 1'b1) return -1;
    if (mr_lv) return qual(mr_lo) ? mr_lo : -1;
    for (int k = 1; k <= M; k++) begin
      if (qual((mr_rr + k) % M)) return (mr_rr + k) % M;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mr_rr = M - 1; mr_dv = 0; mr_down = 0; mr_lv = 0; mr_lo = 0;
  endtask

  task automatic model_update();
    int g;
    bit dv0;
    if (HRESETn !== 1'b1) begin
      model_reset();
      return;
    end
    g   = pick();
    dv0 = mr_dv;
    if (g >= 0 && t_rdy) begin
      mr_rr = g; mr_dv = 1; mr_down = g;
      if (t_lock[g]) begin
        mr_lv = 1; mr_lo = g;
      end else if (mr_lv && g == mr_lo) begin
        mr_lv = 0;
      end
    end else begin
      if (t_rdy) mr_dv = 0;
      if (!dv0 && !qual(mr_lo)) mr_lv = 0;
    end
  endtask

  task automatic model_check();
    int g;
    g = pick();
    check("addr_ack", 256'(bus.m_addr_ack), (g >= 0 && t_rdy) ? (256'(1) << g) : 256'(0));
    check("s_hsel", 256'(bus.S_HSEL), 256'(g >= 0));
    check("s_cmd",
          256'({bus.S_HWRITE, bus.S_HMASTLOCK, bus.S_HTRANS, bus.S_HSIZE, bus.S_HBURST, bus.S_HPROT, bus.S_HADDR}),
          (g >= 0) ? 256'({t_wr[g], t_lock[g], t_trans[g], t_size[g], t_burst[g], t_prot[g], t_addr[g]}) : 256'(0));
    check("data_ack", 256'(bus.m_data_ack), (mr_dv && t_rdy) ? (256'(1) << mr_down) : 256'(0));
    check("s_hwdata", 256'(bus.S_HWDATA), mr_dv ? 256'(t_wdata[mr_down]) : 256'(0));
    check("m_hrdata", 256'(bus.m_hrdata), mr_dv ? (256'(t_rdata) << (32 * mr_down)) : 256'(0));
    check("m_hresp", 256'(bus.m_hresp), (mr_dv && t_resp) ? (256'(1) << mr_down) : 256'(0));
    check("s_hready", 256'(bus.S_HREADY), 256'(t_rdy));
  endtask

  task automatic drive();
    for (int i = 0; i < M; i++) begin
      bus.m_addr_req[i]           = t_req[i];
      bus.m_hsel[i]               = t_sel[i];
      bus.m_hwrite[i]             = t_wr[i];
      bus.m_hmastlock[i]          = t_lock[i];
      bus.m_htrans[2*i +: 2]      = t_trans[i];
      bus.m_hsize[3*i +: 3]       = t_size[i];
      bus.m_hburst[3*i +: 3]      = t_burst[i];
      bus.m_hprot[4*i +: 4]       = t_prot[i];
      bus.m_haddr[32*i +: 32]     = t_addr[i];
      bus.m_hwdata[32*i +: 32]    = t_wdata[i];
    end
    bus.S_HREADYOUT = t_rdy;
    bus.S_HRESP     = t_resp;
    bus.S_HRDATA    = t_rdata;
  endtask

  // Inputs are applied at posedge+1, outputs compared at posedge+5.
  task automatic settle();
    drive();
    #4;
    model_check();
  endtask

  task automatic advance();
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < M; i++) begin
      t_req[i] = 0; t_sel[i] = 0; t_wr[i] = 0; t_lock[i] = 0;
      t_trans[i] = 2'b00; t_size[i] = 3'b0; t_burst[i] = 3'b0; t_prot[i] = 4'h0;
      t_addr[i] = 32'h0; t_wdata[i] = $urandom;
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input bit lk);
    t_req[i] = 1; t_sel[i] = 1; t_wr[i] = wr; t_lock[i] = lk;
    t_trans[i] = 2'b10; t_size[i] = 3'b010; t_burst[i] = 3'b000; t_prot[i] = 4'h3;
    t_addr[i] = a; t_wdata[i] = $urandom;
  endtask

  int exp_ord[4] = '{1, 3, 1, 3};

  initial begin
    idle_all();
    t_rdy = 1; t_resp = 0; t_rdata = 32'h0;
    model_reset();
    @(posedge HCLK); #1;

    // Held in reset with a live request: nothing may be granted.
    set_req(0, 1, 32'h10, 0);
    settle();
    check("rst_aack", 256'(bus.m_addr_ack), 256'(0));
    check("rst_htrans", 256'(bus.S_HTRANS), 256'(0));
    advance();
    t_rdy = 0;
    settle();
    advance();
    t_rdy = 1;
    HRESETn = 1'b1;

    // Single write from M0.
    set_req(0, 1, 32'h0000_0010, 0);
    settle();
    check("wr_aack", 256'(bus.m_addr_ack), 256'(5'b00001));
    advance();
    idle_all();
    settle();
    check("wr_dack", 256'(bus.m_data_ack), 256'(5'b00001));
    check("wr_wdata", 256'(bus.S_HWDATA), 256'(t_wdata[0]));
    advance();

    // Contention between M1 and M3.
    set_req(1, 1, 32'h100, 0);
    set_req(3, 0, 32'h300, 0);
    for (int n = 0; n < 4; n++) begin
      settle();
      check("cont_order", 256'(bus.m_addr_ack), 256'(1) << exp_ord[n]);
      advance();
    end
    idle_all();
    set_req(0, 1, 32'h40, 0);
    set_req(4, 1, 32'h44, 0);
    settle();
    check("rr_after3", 256'(bus.m_addr_ack), 256'(5'b10000));
    advance();
    t_req[4] = 0;
    settle();
    check("rr_wrap", 256'(bus.m_addr_ack), 256'(5'b00001));
    advance();

    // Read with two wait states while M2 waits.
    idle_all();
    set_req(0, 0, 32'h20, 0);
    settle();
    advance();
    idle_all();
    set_req(2, 0, 32'h30, 0);
    t_rdy = 0;
    for (int n = 0; n < 2; n++) begin
      settle();
      check("ws_no_aack", 256'(bus.m_addr_ack), 256'(0));
      advance();
    end
    t_rdy = 1;
    settle();
    check("ws_aack_m2", 256'(bus.m_addr_ack), 256'(5'b00100));
    check("ws_dack_m0", 256'(bus.m_data_ack), 256'(5'b00001));
    advance();
    idle_all();
    t_rdata = 32'hCAFE_0001;
    settle();
    check("ws_rdata_m2", 256'(bus.m_hrdata), 256'(32'hCAFE_0001) << 64);
    advance();

    // Lock held by M0 across two transfers, released by an unlocked transfer.
    set_req(0, 0, 32'h50, 1);
    set_req(1, 0, 32'h60, 0);
    for (int n = 0; n < 2; n++) begin
      settle();
      check("lock_m0", 256'(bus.m_addr_ack), 256'(5'b00001));
      advance();
    end
    t_lock[0] = 0;
    settle();
    check("unlock_m0", 256'(bus.m_addr_ack), 256'(5'b00001));
    advance();
    settle();
    check("lock_m1", 256'(bus.m_addr_ack), 256'(5'b00010));
    advance();

    // Lock released by the owner going idle.
    idle_all();
    set_req(0, 0, 32'h70, 1);
    set_req(1, 1, 32'h80, 0);
    settle();
    check("lki_m0", 256'(bus.m_addr_ack), 256'(5'b00001));
    advance();
    t_req[0] = 0;
    for (int n = 0; n < 2; n++) begin
      settle();
      check("lki_block", 256'(bus.m_addr_ack), 256'(0));
      advance();
    end
    settle();
    check("lki_m1", 256'(bus.m_addr_ack), 256'(5'b00010));
    advance();

    // Two-cycle ERROR response to M1.
    idle_all();
    t_rdy = 0; t_resp = 1;
    settle();
    check("err1_resp", 256'(bus.m_hresp), 256'(5'b00010));
    check("err1_dack", 256'(bus.m_data_ack), 256'(0));
    advance();
    t_rdy = 1;
    settle();
    check("err2_resp", 256'(bus.m_hresp), 256'(5'b00010));
    check("err2_dack", 256'(bus.m_data_ack), 256'(5'b00010));
    advance();
    t_resp = 0;

    // Decode miss.
    set_req(0, 1, 32'h1000_0000, 0);
    settle();
    check("miss_aack", 256'(bus.m_addr_ack), 256'(0));
    check("miss_hsel", 256'(bus.S_HSEL), 256'(0));
    advance();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < M; i++) begin
        t_req[i]   = ($urandom % 2) == 0;
        t_sel[i]   = ($urandom % 8) != 0;
        t_wr[i]    = $urandom % 2;
        t_lock[i]  = ($urandom % 8) == 0;
        t_trans[i] = 2'($urandom);
        t_size[i]  = 3'($urandom);
        t_burst[i] = 3'($urandom);
        t_prot[i]  = 4'($urandom);
        t_addr[i]  = $urandom;
        if (($urandom % 4) != 0) t_addr[i][31:28] = 4'h0;
        t_wdata[i] = $urandom;
      end
      t_rdy   = ($urandom % 4) != 0;
      t_resp  = ($urandom % 8) == 0;
      t_rdata = $urandom;
      settle();
      advance();
    end

    // Reset asserted in the middle of a transfer.
    idle_all();
    t_rdy = 1; t_resp = 0;
    set_req(2, 0, 32'h90, 0);
    settle();
    advance();
    #1;
    HRESETn = 1'b0;
    model_reset();
    #1;
    check("mid_rst_aack", 256'(bus.m_addr_ack), 256'(0));
    check("mid_rst_dack", 256'(bus.m_data_ack), 256'(0));
    settle();
    advance();
    HRESETn = 1'b1;
    set_req(0, 0, 32'hA0, 0);
    settle();
    check("post_rst_m0", 256'(bus.m_addr_ack), 256'(5'b00001));
    advance();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
